// File: rtl/gamepad_pkg.sv
// +------------------------------------------------------------------+
// | gamepad_pkg: button/direction indices shared by the Pmod decoder |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package gamepad_pkg;

  localparam int PAD_BITS = 12;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  function automatic logic [3:0] dir_mask(input logic [PAD_BITS-1:0] bits);
    return {bits[BTN_UP], bits[BTN_DOWN], bits[BTN_LEFT], bits[BTN_RIGHT]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gamepad_pad_decode.sv
// +------------------------------------------------------------------+
// | gamepad_pad_decode: presence, held/pressed and D-pad auto-repeat |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gamepad_pad_decode
  import gamepad_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 3125000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PAD_BITS-1:0] pad_bits,
  input  logic                stale,
  output logic [PAD_BITS-1:0] held,
  output logic [PAD_BITS-1:0] pressed,
  output logic [3:0]          dir_event,
  output logic                is_present
);

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [PAD_BITS-1:0] bits_q;
  logic [PAD_BITS-1:0] held_q;
  logic [RW-1:0]       rpt_cnt;
  logic [RW-1:0]       rpt_next;
  logic [3:0]          mask;
  logic                mask_hold;
  logic                repeat_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q  <= '1;
      held_q  <= '0;
      rpt_cnt <= '0;
    end else begin
      bits_q  <= pad_bits;
      held_q  <= held;
      rpt_cnt <= rpt_next;
    end
  end

  // The cycle in which the mask changes counts as count 0, so the
  // register already holds 1 on the following cycle.
  always_comb begin
    is_present   = (bits_q != '1) && !stale;
    held         = is_present ? bits_q : '0;
    pressed      = held & ~held_q;
    mask         = dir_mask(held);
    mask_hold    = (mask != 4'b0) && (mask == dir_mask(held_q));
    repeat_pulse = mask_hold && (rpt_cnt == RPT_LAST);
    rpt_next     = rpt_cnt + 1'b1;
    if (mask == 4'b0) begin
      rpt_next = '0;
    end else if (!mask_hold) begin
      rpt_next = RW'(1);
    end else if (repeat_pulse) begin
      rpt_next = RPT_RELOAD;
    end
    dir_event = dir_mask(pressed) | (repeat_pulse ? mask : 4'b0);
  end

endmodule

`default_nettype wire

// File: rtl/gamepad_pmod_multi.sv
// +------------------------------------------------------------------+
// | gamepad_pmod_multi: Gamepad Pmod serial front end, 1..4 pads     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gamepad_pmod_multi
  import gamepad_pkg::*;
#(
  parameter int N_PADS        = 1,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 3125000,
  parameter int TIMEOUT       = 2500000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pmod_data,
  input  logic                       pmod_clk,
  input  logic                       pmod_latch,
  output logic [PAD_BITS*N_PADS-1:0] held,
  output logic [PAD_BITS*N_PADS-1:0] pressed,
  output logic [4*N_PADS-1:0]        dir_event,
  output logic [N_PADS-1:0]          is_present,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic                       stale
);

  localparam int FRAME_BITS = PAD_BITS * N_PADS;
  localparam int CW         = $clog2(FRAME_BITS + 2);
  localparam int TW         = $clog2(TIMEOUT + 1);

  logic [1:0]            data_sync;
  logic [2:0]            sclk_sync;
  logic [2:0]            latch_sync;
  logic                  sclk_rise;
  logic                  latch_rise;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame;
  logic [CW-1:0]         bit_cnt;
  logic [TW-1:0]         idle_cnt;

  assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
  assign latch_rise = latch_sync[1] & ~latch_sync[2];
  assign stale      = (idle_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync   <= '0;
      sclk_sync   <= '0;
      latch_sync  <= '0;
      shift_reg   <= '1;
      frame       <= '1;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_sync   <= {data_sync[0], pmod_data};
      sclk_sync   <= {sclk_sync[1:0], pmod_clk};
      latch_sync  <= {latch_sync[1:0], pmod_latch};
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (sclk_rise) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], data_sync[1]};
      end

      // A bit arriving with the latch belongs to the next frame.
      if (latch_rise) begin
        if (bit_cnt == CW'(FRAME_BITS)) begin
          frame       <= shift_reg;
          frame_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
        bit_cnt <= sclk_rise ? CW'(1) : '0;
      end else if (sclk_rise && (bit_cnt != CW'(FRAME_BITS + 1))) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (frame_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TW'(TIMEOUT)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    gamepad_pad_decode #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_pad (
      .clk        (clk),
      .reset      (reset),
      .pad_bits   (frame[PAD_BITS*p +: PAD_BITS]),
      .stale      (stale),
      .held       (held[PAD_BITS*p +: PAD_BITS]),
      .pressed    (pressed[PAD_BITS*p +: PAD_BITS]),
      .dir_event  (dir_event[4*p +: 4]),
      .is_present (is_present[p])
    );
  end

endmodule

`default_nettype wire
